// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, ACK/NACK bus levels, byte width.
package i2c_slave_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      WAIT_STOP
   } state_t;

   localparam logic ACK        = 1'b0;
   localparam logic NACK       = 1'b1;
   localparam int   I2C_BYTE_W = 8;

endpackage

// File: rtl/i2c_slave_filter.sv
// scl/sda front end: 2-flop sync, optional glitch filter (I2C_SLAVE_GLITCH_FILTER_EN), edge/START/STOP strobes.
// Latency: 2 clks to strobes (+FILT_LEN-1 with the filter); no backpressure, strobes are one-clk pulses.
module i2c_slave_filter
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
#(
   parameter int FILT_LEN = 3
)
`endif
(
   input  logic clk,
   input  logic PRESETn,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_lvl,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   // bit 1 carries scl, bit 0 carries sda; everything resets to the idle-high bus level
   logic [1:0] sync_1, sync_2, filt, prev;

   always_ff @(posedge clk) begin
      if (!PRESETn) begin
         sync_1 <= 2'b11;
         sync_2 <= 2'b11;
         prev   <= 2'b11;
      end else begin
         sync_1 <= {scl_i, sda_i};
         sync_2 <= sync_1;
         prev   <= filt;
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   for (genvar i = 0; i < 2; i++) begin : g_filt
      logic [FILT_LEN-2:0] hist;
      logic [FILT_LEN-1:0] win;
      logic                hold;

      // the newest sample plus FILT_LEN-1 older ones must all agree before the level moves
      assign win     = {hist, sync_2[i]};
      assign filt[i] = (&win) ? 1'b1 : ((|win) ? hold : 1'b0);

      always_ff @(posedge clk) begin
         if (!PRESETn) begin
            hist <= '1;
            hold <= 1'b1;
         end else begin
            hist <= win[FILT_LEN-2:0];
            hold <= filt[i];
         end
      end
   end
`else
   assign filt = sync_2;
`endif

   assign sda_lvl   = filt[0];
   assign scl_rise  =  filt[1] & ~prev[1];
   assign scl_fall  = ~filt[1] &  prev[1];
   assign start_det =  filt[1] & prev[1] &  prev[0] & ~filt[0];
   assign stop_det  =  filt[1] & prev[1] & ~prev[0] &  filt[0];

endmodule

// File: rtl/i2c_slave_target.sv
// I2C target with auto-incrementing byte register file; optional input glitch filter via I2C_SLAVE_GLITCH_FILTER_EN.
// Latency: sda_oe moves the clk after a detected scl_fall; no backpressure (never stretches SCL).
module i2c_slave_target
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         REG_AW     = 3
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   ,
   parameter int         FILT_LEN   = 3
`endif
) (
   input  logic              clk,
   input  logic              PRESETn,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   output logic              wr_valid,
   output logic [REG_AW-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [7:0]        dbg_data
);

   localparam int         DEPTH    = 2 ** REG_AW;
   localparam logic [3:0] BYTE_END = 4'(I2C_BYTE_W);
   localparam logic [3:0] LAST_BIT = 4'(I2C_BYTE_W - 1);

   state_t                  state_q, state_d;
   logic [3:0]              bit_cnt;
   logic [I2C_BYTE_W-1:0]   shreg;
   logic                    rw_q;
   logic [REG_AW-1:0]       ptr;
   logic [7:0]              regs [DEPTH];
   logic                    sda_oe_d;
   logic                    sda_lvl, scl_rise, scl_fall, start_det, stop_det;
   logic                    byte_done, addr_match;

   i2c_slave_filter
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      #(.FILT_LEN(FILT_LEN))
`endif
      u_filter (
         .clk       (clk),
         .PRESETn   (PRESETn),
         .scl_i     (scl_i),
         .sda_i     (sda_i),
         .sda_lvl   (sda_lvl),
         .scl_rise  (scl_rise),
         .scl_fall  (scl_fall),
         .start_det (start_det),
         .stop_det  (stop_det)
      );

   assign byte_done  = (bit_cnt == BYTE_END);
   assign addr_match = (shreg[7:1] == SLAVE_ADDR);
   assign dbg_data   = regs[dbg_addr];

   always_ff @(posedge clk) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start_det)     state_d = ADDR;
      else if (stop_det) state_d = IDLE;
      else begin
         case (state_q)
            ADDR:      if (scl_fall && byte_done) state_d = addr_match ? ADDR_ACK : WAIT_STOP;
            ADDR_ACK:  if (scl_fall) state_d = rw_q ? RDATA : PTR;
            PTR:       if (scl_fall && byte_done) state_d = PTR_ACK;
            PTR_ACK:   if (scl_fall) state_d = WDATA;
            WDATA:     if (scl_fall && byte_done) state_d = WDATA_ACK;
            WDATA_ACK: if (scl_fall) state_d = WDATA;
            RDATA:     if (scl_fall && byte_done) state_d = RDATA_ACK;
            // bit_cnt is cleared by the master's ACK; that is what re-arms the next byte
            RDATA_ACK: begin
               if (scl_rise && sda_lvl == NACK)      state_d = WAIT_STOP;
               else if (scl_fall && bit_cnt == 4'd0) state_d = RDATA;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sda_oe_d = sda_oe;
      if (start_det || stop_det) sda_oe_d = 1'b0;
      else if (scl_fall) begin
         case (state_q)
            ADDR:         sda_oe_d = byte_done && addr_match;
            ADDR_ACK:     sda_oe_d = rw_q ? ~regs[ptr][7] : 1'b0;
            PTR, WDATA:   sda_oe_d = byte_done;
            RDATA:        sda_oe_d = byte_done ? 1'b0 : ~shreg[6];
            RDATA_ACK:    sda_oe_d = (bit_cnt == 4'd0) ? ~regs[ptr][7] : 1'b0;
            default:      sda_oe_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!PRESETn) begin
         sda_oe   <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         ptr      <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         rw_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         wr_valid <= 1'b0;
         sda_oe   <= sda_oe_d;
         if (start_det) begin
            bit_cnt <= '0;
            busy    <= 1'b1;
         end else if (stop_det) begin
            busy <= 1'b0;
         end else if (scl_rise) begin
            case (state_q)
               ADDR, PTR, WDATA: begin
                  shreg   <= {shreg[6:0], sda_lvl};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (state_q == WDATA && bit_cnt == LAST_BIT) begin
                     regs[ptr] <= {shreg[6:0], sda_lvl};
                     wr_valid  <= 1'b1;
                     wr_addr   <= ptr;
                     wr_data   <= {shreg[6:0], sda_lvl};
                     ptr       <= ptr + 1'b1;
                  end
               end
               RDATA:     bit_cnt <= bit_cnt + 4'd1;
               RDATA_ACK: if (sda_lvl == ACK) begin
                  ptr     <= ptr + 1'b1;
                  bit_cnt <= '0;
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state_q)
               ADDR:     if (byte_done) rw_q <= shreg[0];
               ADDR_ACK: begin
                  bit_cnt <= '0;
                  shreg   <= regs[ptr];
               end
               PTR:      if (byte_done) ptr <= shreg[REG_AW-1:0];
               PTR_ACK, WDATA_ACK: bit_cnt <= '0;
               RDATA:    shreg <= {shreg[6:0], 1'b0};
               RDATA_ACK: if (bit_cnt == 4'd0) shreg <= regs[ptr];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: acts as the I2C master on a wired-AND SDA line.
module tb_i2c_slave_target;
   import i2c_slave_pkg::*;

   localparam int H = 8;

   logic       clk = 1'b0;
   logic       PRESETn, scl_m, sda_m;
   logic       sda_oe, wr_valid, busy;
   logic [2:0] wr_addr, dbg_addr;
   logic [7:0] wr_data, dbg_data;
   wire        sda_bus = sda_m & ~sda_oe;

   int         checks = 0;
   int         failures = 0;
   logic [2:0] log_addr [$];
   logic [7:0] log_data [$];
   logic       oe_seen, busy_seen;
   logic       ack;
   logic [7:0] rd;

   always #5 clk = ~clk;

   i2c_slave_target dut (
      .clk      (clk),
      .PRESETn  (PRESETn),
      .scl_i    (scl_m),
      .sda_i    (sda_bus),
      .sda_oe   (sda_oe),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always @(negedge clk) begin
      if (wr_valid) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
      end
      if (sda_oe) oe_seen = 1'b1;
      if (busy)   busy_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clk_bit(input logic b, output logic s);
      sda_m = b;
      wait_clk(H);
      scl_m = 1'b1;
      wait_clk(H / 2);
      s = sda_bus;
      wait_clk(H / 2);
      scl_m = 1'b0;
      wait_clk(2);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_clk(H);
      scl_m = 1'b1; wait_clk(H);
      sda_m = 1'b0; wait_clk(H);
      scl_m = 1'b0; wait_clk(H);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_clk(H);
      scl_m = 1'b1; wait_clk(H);
      sda_m = 1'b1; wait_clk(H);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic a);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, a);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(mack, s);
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
      dbg_addr = a;
      #1;
      d = dbg_data;
   endtask

   initial begin
      PRESETn  = 1'b0;
      scl_m    = 1'b1;
      sda_m    = 1'b1;
      dbg_addr = 3'd0;
      wait_clk(5);
      check("rst_sda_oe",   32'(sda_oe),   32'h0);
      check("rst_busy",     32'(busy),     32'h0);
      check("rst_wr_valid", 32'(wr_valid), 32'h0);
      check("rst_wr_addr",  32'(wr_addr),  32'h0);
      check("rst_wr_data",  32'(wr_data),  32'h0);
      rd_reg(3'd5, rd);
      check("rst_reg5", 32'(rd), 32'h0);
      PRESETn = 1'b1;
      wait_clk(5);

      // write burst 0xA0, ptr 2, 0x5A, 0xC3
      i2c_start();
      check("wr_busy_after_start", 32'(busy), 32'h1);
      write_byte(8'hA0, ack); check("wr_ack_addr", 32'(ack), 32'h0);
      write_byte(8'h02, ack); check("wr_ack_ptr",  32'(ack), 32'h0);
      write_byte(8'h5A, ack); check("wr_ack_d0",   32'(ack), 32'h0);
      write_byte(8'hC3, ack); check("wr_ack_d1",   32'(ack), 32'h0);
      i2c_stop();
      wait_clk(4);
      check("wr_count", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         check("wr0_addr", 32'(log_addr[0]), 32'h2);
         check("wr0_data", 32'(log_data[0]), 32'h5A);
         check("wr1_addr", 32'(log_addr[1]), 32'h3);
         check("wr1_data", 32'(log_data[1]), 32'hC3);
      end
      rd_reg(3'd2, rd); check("reg2", 32'(rd), 32'h5A);
      rd_reg(3'd3, rd); check("reg3", 32'(rd), 32'hC3);
      check("busy_after_stop", 32'(busy), 32'h0);

      // pointer set, repeated start, read two bytes
      i2c_start();
      write_byte(8'hA0, ack); check("rd_ack_addr_w", 32'(ack), 32'h0);
      write_byte(8'h02, ack); check("rd_ack_ptr",    32'(ack), 32'h0);
      i2c_start();
      write_byte(8'hA1, ack); check("rd_ack_addr_r", 32'(ack), 32'h0);
      read_byte(ACK, rd);     check("rd_byte0", 32'(rd), 32'h5A);
      read_byte(NACK, rd);    check("rd_byte1", 32'(rd), 32'hC3);
      wait_clk(4);
      check("rd_released", 32'(sda_oe), 32'h0);
      check("rd_ptr", 32'(dut.ptr), 32'h3);
      i2c_stop();
      wait_clk(4);

      // address mismatch: nothing driven, nothing written
      log_addr.delete();
      log_data.delete();
      oe_seen = 1'b0;
      i2c_start();
      write_byte(8'hA2, ack); check("mm_nack_addr", 32'(ack), 32'h1);
      write_byte(8'h00, ack); check("mm_nack_b1",   32'(ack), 32'h1);
      write_byte(8'hFF, ack); check("mm_nack_b2",   32'(ack), 32'h1);
      i2c_stop();
      wait_clk(4);
      check("mm_oe_seen", 32'(oe_seen), 32'h0);
      check("mm_wr_count", 32'(log_addr.size()), 32'd0);
      rd_reg(3'd2, rd); check("mm_reg2", 32'(rd), 32'h5A);

      // pointer wrap 7 -> 0, then pointer byte 0xFD selects reg 5
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h07, ack);
      write_byte(8'h11, ack);
      write_byte(8'h22, ack); check("wrap_ack_d1", 32'(ack), 32'h0);
      i2c_stop();
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'hFD, ack);
      write_byte(8'h77, ack);
      i2c_stop();
      wait_clk(4);
      check("wrap_count", 32'(log_addr.size()), 32'd3);
      if (log_addr.size() == 3) begin
         check("wrap0_addr", 32'(log_addr[0]), 32'h7);
         check("wrap1_addr", 32'(log_addr[1]), 32'h0);
         check("wrap2_addr", 32'(log_addr[2]), 32'h5);
         check("wrap2_data", 32'(log_data[2]), 32'h77);
      end
      rd_reg(3'd7, rd); check("reg7", 32'(rd), 32'h11);
      rd_reg(3'd0, rd); check("reg0", 32'(rd), 32'h22);
      rd_reg(3'd5, rd); check("reg5", 32'(rd), 32'h77);

      // reset while the target drives bit7 (0) of reg 2
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h02, ack);
      i2c_start();
      write_byte(8'hA1, ack);
      wait_clk(3);
      check("mid_driving", 32'(sda_oe), 32'h1);
      PRESETn = 1'b0;
      wait_clk(1);
      check("mid_rst_oe",   32'(sda_oe),  32'h0);
      check("mid_rst_busy", 32'(busy),    32'h0);
      check("mid_rst_ptr",  32'(dut.ptr), 32'h0);
      rd_reg(3'd2, rd); check("mid_rst_reg2", 32'(rd), 32'h0);
      rd_reg(3'd7, rd); check("mid_rst_reg7", 32'(rd), 32'h0);
      PRESETn = 1'b1;
      sda_m   = 1'b1;
      scl_m   = 1'b1;
      wait_clk(10);
      log_addr.delete();
      log_data.delete();
      i2c_start();
      write_byte(8'hA0, ack); check("post_ack_addr", 32'(ack), 32'h0);
      write_byte(8'h04, ack);
      write_byte(8'h99, ack); check("post_ack_data", 32'(ack), 32'h0);
      i2c_stop();
      wait_clk(4);
      check("post_count", 32'(log_addr.size()), 32'd1);
      rd_reg(3'd4, rd); check("post_reg4", 32'(rd), 32'h99);

      // one-clk low pulse on SDA with SCL high
      wait_clk(10);
      busy_seen = 1'b0;
      sda_m = 1'b0;
      wait_clk(1);
      sda_m = 1'b1;
      wait_clk(12);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
      check("glitch_busy_seen", 32'(busy_seen), 32'h0);
`else
      check("glitch_busy_seen", 32'(busy_seen), 32'h1);
`endif
      check("glitch_busy_end", 32'(busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
